mul_acc_feeder: RTL and testbench
=================================

Name: mul_acc_feeder

Overview:
Row-level driver for the SpMV multiply-accumulate unit, sitting on the opposite side of its A/B operand streams and result stream. Accepts row commands {row_id, row_len} and pairs matrix-value and vector-value streams into lock-step A/B transfers, asserting A tlast on each row's final pair. Consumes the unit's result stream, which has no backpressure, and tags each row total with its row_id. Emits {row_id, sum} to the SpMV writeback path under credit control, so no result is ever dropped.

Parameters:
DATA_W, 32, operand/result width (IEEE-754 single)
LEN_W, 16, row_len width
ROW_W, 32, row_id width
RES_DEPTH, 4, max rows outstanding; depth of id FIFO and result FIFO (power of 2, >=2)

Ports:
aclk_0  in  1  clock
aresetn_0  in  1  synchronous active-low reset
s_cmd_tdata  in  ROW_W+LEN_W  {row_id, row_len}
s_cmd_tvalid  in  1  command valid
s_cmd_tready  out  1  command ready
s_val_tdata  in  DATA_W  matrix nonzero value
s_val_tvalid / s_val_tready  in / out  1  value handshake
s_vec_tdata  in  DATA_W  gathered vector element
s_vec_tvalid / s_vec_tready  in / out  1  vector handshake
M_AXIS_A_0_tdata  out  DATA_W  operand A (matrix value)
M_AXIS_A_0_tlast  out  1  last pair of row
M_AXIS_A_0_tvalid / M_AXIS_A_0_tready  out / in  1  A handshake
M_AXIS_B_0_tdata  out  DATA_W  operand B (vector value)
M_AXIS_B_0_tvalid / M_AXIS_B_0_tready  out / in  1  B handshake
S_AXIS_RESULT_0_tdata  in  DATA_W  accumulator output
S_AXIS_RESULT_0_tlast  in  1  row total marker
S_AXIS_RESULT_0_tvalid  in  1  result valid (no ready)
m_res_tdata  out  ROW_W+DATA_W  {row_id, sum}
m_res_tvalid / m_res_tready  out / in  1  result handshake
err_orphan  out  1  sticky: row total arrived with empty id FIFO

Behaviour:
- Reset values: all tvalid outputs 0; M_AXIS_A_0_tlast 0; s_cmd_tready 0; s_val_tready/s_vec_tready 0; err_orphan 0. FIFOs empty, outstanding=0, FSM=IDLE. Reset mid-row discards all state; the accumulator shares the reset.
- FSM IDLE: s_cmd_tready = (outstanding < RES_DEPTH). On cmd handshake: latch row_len into remaining; push row_id to id FIFO; outstanding++. Go to ZERO if row_len==0, else STREAM.
- Operand slot: a_pend/b_pend flags, each cleared on its own channel handshake. slot_free = (!a_pend | A_tready) & (!b_pend | B_tready).
- STREAM: load = s_val_tvalid & s_vec_tvalid & slot_free. s_val_tready = s_vec_tready = slot_free & both valid, so both inputs are consumed in the same cycle.
  - On load: A/B data registered; a_pend=b_pend=1; A tlast = (remaining==1); remaining--.
  - Load at remaining==1 returns the FSM to IDLE.
  - Latency: input handshake -> A/B tvalid next cycle. Full throughput is 1 pair/cycle.
  - A and B may complete on different cycles; no reload until both have completed.
- ZERO: when slot_free, load A=B=0x00000000 with tlast=1, then return to IDLE. Row ordering is preserved.
- Result side: S_AXIS_RESULT_0_tvalid with tlast=0 is ignored (partial sums). With tlast=1: pop id FIFO and write {id, tdata} to the result FIFO in the same cycle. If the id FIFO is empty: drop, set err_orphan (cleared only by reset).
- m_res_tvalid = result FIFO non-empty. On m_res handshake: pop, outstanding--. Simultaneous cmd accept and m_res pop leave outstanding unchanged.
- The credit scheme guarantees neither FIFO overflows; an overflow is a design error (assertion).

Optional Feature:
FEEDER_PERF_CNT_EN:
- Defined: adds outputs perf_pairs (32b, +1 per completed A handshake) and perf_stall (32b, +1 per cycle with (a_pend & !A_tready) | (b_pend & !B_tready)). Both are free-running, wrap at 2^32, and reset to 0.
- Undefined: these ports and counters are absent.

Test Plan:
- cmd {id=5, len=3}; vals 1.0, 2.0, 3.0; vec 1.0 ×3 -> 3 A/B transfers, tlast only on the 3rd; result tlast 0x40C00000 -> m_res {5, 0x40C00000}.
- cmd {id=9, len=0} -> one A/B pair 0x0/0x0 with tlast=1; result 0x0 -> m_res {9, 0x0}.
- A_tready low 4 cycles, B_tready high, len=2 -> B completes once; s_val_tready/s_vec_tready stay 0 until A completes; exactly 2 pairs delivered, no loss or duplication.
- RES_DEPTH=4, m_res_tready=0, 5 cmds of len=1 -> s_cmd_tready drops after 4th accept; rises the cycle after the first m_res pop; m_res order is ids 0..3 then 4.
- Result tvalid with tlast=0 -> no m_res; result tlast with empty id FIFO -> err_orphan=1 and held; no m_res.
- aresetn_0 low mid-row (remaining=2) -> next cycle all tvalid 0 and err_orphan 0; after release s_cmd_tready=1 and a new len=1 row completes normally.

Source files
------------

// File: rtl/mul_acc_feeder.sv
`default_nettype none
// =============================================================================
// mul_acc_feeder : SpMV row driver - pairs value/vector streams into A/B
// operands and tags each row total with its row_id. Option: FEEDER_PERF_CNT_EN
// Revision 1.0
// =============================================================================
module mul_acc_feeder #(
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int ROW_W     = 32,
  parameter int RES_DEPTH = 4
) (
  input  logic                    aclk_0,
  input  logic                    aresetn_0,

  input  logic [ROW_W+LEN_W-1:0]  s_cmd_tdata,
  input  logic                    s_cmd_tvalid,
  output logic                    s_cmd_tready,

  input  logic [DATA_W-1:0]       s_val_tdata,
  input  logic                    s_val_tvalid,
  output logic                    s_val_tready,

  input  logic [DATA_W-1:0]       s_vec_tdata,
  input  logic                    s_vec_tvalid,
  output logic                    s_vec_tready,

  output logic [DATA_W-1:0]       M_AXIS_A_0_tdata,
  output logic                    M_AXIS_A_0_tlast,
  output logic                    M_AXIS_A_0_tvalid,
  input  logic                    M_AXIS_A_0_tready,

  output logic [DATA_W-1:0]       M_AXIS_B_0_tdata,
  output logic                    M_AXIS_B_0_tvalid,
  input  logic                    M_AXIS_B_0_tready,

  input  logic [DATA_W-1:0]       S_AXIS_RESULT_0_tdata,
  input  logic                    S_AXIS_RESULT_0_tlast,
  input  logic                    S_AXIS_RESULT_0_tvalid,

  output logic [ROW_W+DATA_W-1:0] m_res_tdata,
  output logic                    m_res_tvalid,
  input  logic                    m_res_tready,

  output logic                    err_orphan
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]             perf_pairs,
  output logic [31:0]             perf_stall
`endif
);

  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RES_W = ROW_W + DATA_W;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RES_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W+1)'(1);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_ZERO   = 2'd2;

  logic [1:0]        state;
  logic [LEN_W-1:0]  remaining;
  logic [CNT_W-1:0]  outstanding;

  logic              a_pend;
  logic              b_pend;
  logic              a_last;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;

  logic [ROW_W-1:0]  cmd_row;
  logic [LEN_W-1:0]  cmd_len;
  logic              slot_free;
  logic              cmd_fire;
  logic              load_pair;
  logic              load_zero;
  logic              res_fire;

  // ID FIFO: row_ids waiting for their row total
  logic [ROW_W-1:0]  id_mem [RES_DEPTH];
  logic [PTR_W:0]    id_wr;
  logic [PTR_W:0]    id_rd;
  logic              id_empty;
  logic              id_full;
  logic              id_pop;

  // Result FIFO: tagged totals waiting for the writeback path
  logic [RES_W-1:0]  rf_mem [RES_DEPTH];
  logic [PTR_W:0]    rf_wr;
  logic [PTR_W:0]    rf_rd;
  logic              rf_empty;
  logic              rf_full;

  logic              row_total;

  assign {cmd_row, cmd_len} = s_cmd_tdata;

  // The slot may be reloaded in the same cycle its pending beats complete.
  assign slot_free = (!a_pend || M_AXIS_A_0_tready) && (!b_pend || M_AXIS_B_0_tready);

  assign s_cmd_tready = aresetn_0 && (state == S_IDLE) && (outstanding < DEPTH_CNT);
  assign cmd_fire     = s_cmd_tvalid && s_cmd_tready;

  assign load_pair    = (state == S_STREAM) && slot_free && s_val_tvalid && s_vec_tvalid;
  assign load_zero    = (state == S_ZERO) && slot_free;
  assign s_val_tready = load_pair;
  assign s_vec_tready = load_pair;

  always_ff @(posedge aclk_0) begin
    if (!aresetn_0) begin
      state     <= S_IDLE;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            remaining <= cmd_len;
            state     <= (cmd_len == '0) ? S_ZERO : S_STREAM;
          end
        end
        S_STREAM: begin
          if (load_pair) begin
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state <= S_IDLE;
            end
          end
        end
        S_ZERO: begin
          if (load_zero) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk_0) begin
    if (!aresetn_0) begin
      a_pend <= 1'b0;
      b_pend <= 1'b0;
      a_last <= 1'b0;
      a_data <= '0;
      b_data <= '0;
    end else if (load_pair || load_zero) begin
      a_pend <= 1'b1;
      b_pend <= 1'b1;
      a_last <= load_zero || (remaining == LEN_ONE);
      a_data <= load_zero ? '0 : s_val_tdata;
      b_data <= load_zero ? '0 : s_vec_tdata;
    end else begin
      if (M_AXIS_A_0_tready) begin
        a_pend <= 1'b0;
      end
      if (M_AXIS_B_0_tready) begin
        b_pend <= 1'b0;
      end
    end
  end

  assign M_AXIS_A_0_tdata  = a_data;
  assign M_AXIS_A_0_tlast  = a_last;
  assign M_AXIS_A_0_tvalid = a_pend;
  assign M_AXIS_B_0_tdata  = b_data;
  assign M_AXIS_B_0_tvalid = b_pend;

  assign id_empty  = (id_wr == id_rd);
  assign id_full   = (id_wr[PTR_W] != id_rd[PTR_W]) &&
                     (id_wr[PTR_W-1:0] == id_rd[PTR_W-1:0]);
  assign row_total = S_AXIS_RESULT_0_tvalid && S_AXIS_RESULT_0_tlast;
  assign id_pop    = row_total && !id_empty;

  always_ff @(posedge aclk_0) begin
    if (cmd_fire) begin
      id_mem[id_wr[PTR_W-1:0]] <= cmd_row;
    end
  end

  always_ff @(posedge aclk_0) begin
    if (!aresetn_0) begin
      id_wr <= '0;
      id_rd <= '0;
    end else begin
      if (cmd_fire) begin
        id_wr <= id_wr + PTR_ONE;
      end
      if (id_pop) begin
        id_rd <= id_rd + PTR_ONE;
      end
    end
  end

  assign rf_empty     = (rf_wr == rf_rd);
  assign rf_full      = (rf_wr[PTR_W] != rf_rd[PTR_W]) &&
                        (rf_wr[PTR_W-1:0] == rf_rd[PTR_W-1:0]);
  assign m_res_tvalid = !rf_empty;
  assign m_res_tdata  = rf_mem[rf_rd[PTR_W-1:0]];
  assign res_fire     = m_res_tvalid && m_res_tready;

  always_ff @(posedge aclk_0) begin
    if (id_pop) begin
      rf_mem[rf_wr[PTR_W-1:0]] <= {id_mem[id_rd[PTR_W-1:0]], S_AXIS_RESULT_0_tdata};
    end
  end

  always_ff @(posedge aclk_0) begin
    if (!aresetn_0) begin
      rf_wr <= '0;
      rf_rd <= '0;
    end else begin
      if (id_pop) begin
        rf_wr <= rf_wr + PTR_ONE;
      end
      if (res_fire) begin
        rf_rd <= rf_rd + PTR_ONE;
      end
    end
  end

  // Credits cover rows from command accept until their tagged total is popped.
  always_ff @(posedge aclk_0) begin
    if (!aresetn_0) begin
      outstanding <= '0;
    end else if (cmd_fire && !res_fire) begin
      outstanding <= outstanding + CNT_ONE;
    end else if (!cmd_fire && res_fire) begin
      outstanding <= outstanding - CNT_ONE;
    end
  end

  always_ff @(posedge aclk_0) begin
    if (!aresetn_0) begin
      err_orphan <= 1'b0;
    end else if (row_total && id_empty) begin
      err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge aclk_0) begin
    if (aresetn_0) begin
      assert (!(cmd_fire && id_full));
      assert (!(id_pop && rf_full));
    end
  end

`ifdef FEEDER_PERF_CNT_EN
  always_ff @(posedge aclk_0) begin
    if (!aresetn_0) begin
      perf_pairs <= '0;
      perf_stall <= '0;
    end else begin
      if (a_pend && M_AXIS_A_0_tready) begin
        perf_pairs <= perf_pairs + 32'd1;
      end
      if ((a_pend && !M_AXIS_A_0_tready) || (b_pend && !M_AXIS_B_0_tready)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_acc_feeder.sv
`default_nettype none
// tb_mul_acc_feeder : randomized scoreboard bench for mul_acc_feeder.
module tb_mul_acc_feeder;

  logic        clk;
  logic        aresetn;
  logic [47:0] s_cmd_tdata;
  logic        s_cmd_tvalid, s_cmd_tready;
  logic [31:0] s_val_tdata;
  logic        s_val_tvalid, s_val_tready;
  logic [31:0] s_vec_tdata;
  logic        s_vec_tvalid, s_vec_tready;
  logic [31:0] a_tdata;
  logic        a_tlast, a_tvalid, a_tready;
  logic [31:0] b_tdata;
  logic        b_tvalid, b_tready;
  logic [31:0] r_tdata;
  logic        r_tlast, r_tvalid;
  logic [63:0] m_res_tdata;
  logic        m_res_tvalid, m_res_tready;
  logic        err_orphan;

  mul_acc_feeder dut (
    .aclk_0(clk), .aresetn_0(aresetn),
    .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
    .s_val_tdata(s_val_tdata), .s_val_tvalid(s_val_tvalid), .s_val_tready(s_val_tready),
    .s_vec_tdata(s_vec_tdata), .s_vec_tvalid(s_vec_tvalid), .s_vec_tready(s_vec_tready),
    .M_AXIS_A_0_tdata(a_tdata), .M_AXIS_A_0_tlast(a_tlast),
    .M_AXIS_A_0_tvalid(a_tvalid), .M_AXIS_A_0_tready(a_tready),
    .M_AXIS_B_0_tdata(b_tdata), .M_AXIS_B_0_tvalid(b_tvalid), .M_AXIS_B_0_tready(b_tready),
    .S_AXIS_RESULT_0_tdata(r_tdata), .S_AXIS_RESULT_0_tlast(r_tlast),
    .S_AXIS_RESULT_0_tvalid(r_tvalid),
    .m_res_tdata(m_res_tdata), .m_res_tvalid(m_res_tvalid), .m_res_tready(m_res_tready),
    .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: what the DUT must emit, in order.
  logic [47:0] cmd_q[$];
  logic [31:0] val_q[$];
  logic [31:0] vec_q[$];
  logic [32:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [63:0] exp_res[$];
  logic [31:0] sum_q[$];
  logic [32:0] inj_q[$];
  logic [31:0] stg_val[$];
  logic [31:0] stg_vec[$];

  int bubbles = 0;
  int partials = 0;
  int a_mode = 2, b_mode = 2, r_mode = 2;   // 0 random, 1 low, 2 high
  int cmd_acc = 0, a_fires = 0, b_fires = 0, a_last_cnt = 0, res_sent = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Row model: A stream is the value list with tlast on the final element;
  // an empty row contributes a single zero pair with tlast.
  task automatic add_row(input logic [31:0] id, input logic [15:0] len, input logic [31:0] sum);
    logic [31:0] v, w;
    cmd_q.push_back({id, len});
    if (len == 16'd0) begin
      exp_a.push_back({1'b1, 32'h0});
      exp_b.push_back(32'h0);
    end
    for (int i = 0; i < int'(len); i++) begin
      v = (stg_val.size() > 0) ? stg_val.pop_front() : $urandom;
      w = (stg_vec.size() > 0) ? stg_vec.pop_front() : $urandom;
      val_q.push_back(v);
      vec_q.push_back(w);
      exp_a.push_back({(i == int'(len) - 1), v});
      exp_b.push_back(w);
    end
    sum_q.push_back(sum);
    exp_res.push_back({id, sum});
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((cmd_q.size() + val_q.size() + exp_a.size() + exp_b.size() + exp_res.size()) != 0
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 64'(cmd_q.size() + exp_a.size() + exp_b.size() + exp_res.size()), 64'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic pick(input int mode);
    if (mode == 1) return 1'b0;
    if (mode == 2) return 1'b1;
    return ($urandom_range(0, 3) != 0);
  endfunction

  initial begin : cmd_drv
    bit fired = 1'b0;
    s_cmd_tvalid = 1'b0;
    s_cmd_tdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (fired || !aresetn) begin
        s_cmd_tvalid = 1'b0;
        fired = 1'b0;
      end
      if (aresetn && !s_cmd_tvalid && cmd_q.size() > 0 && (bubbles == 0 || $urandom_range(0, 2) != 0)) begin
        s_cmd_tvalid = 1'b1;
        s_cmd_tdata  = cmd_q[0];
      end
      @(negedge clk);
      if (aresetn && s_cmd_tvalid && s_cmd_tready) begin
        fired = 1'b1;
        cmd_acc++;
        if (cmd_q.size() > 0) void'(cmd_q.pop_front());
      end
    end
  end

  initial begin : val_drv
    bit fired = 1'b0;
    s_val_tvalid = 1'b0;
    s_val_tdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (fired || !aresetn) begin
        s_val_tvalid = 1'b0;
        fired = 1'b0;
      end
      if (aresetn && !s_val_tvalid && val_q.size() > 0 && (bubbles == 0 || $urandom_range(0, 3) != 0)) begin
        s_val_tvalid = 1'b1;
        s_val_tdata  = val_q[0];
      end
      @(negedge clk);
      if (aresetn && s_val_tvalid && s_val_tready) begin
        fired = 1'b1;
        if (val_q.size() > 0) void'(val_q.pop_front());
      end
    end
  end

  initial begin : vec_drv
    bit fired = 1'b0;
    s_vec_tvalid = 1'b0;
    s_vec_tdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (fired || !aresetn) begin
        s_vec_tvalid = 1'b0;
        fired = 1'b0;
      end
      if (aresetn && !s_vec_tvalid && vec_q.size() > 0 && (bubbles == 0 || $urandom_range(0, 3) != 0)) begin
        s_vec_tvalid = 1'b1;
        s_vec_tdata  = vec_q[0];
      end
      @(negedge clk);
      if (aresetn && s_vec_tvalid && s_vec_tready) begin
        fired = 1'b1;
        if (vec_q.size() > 0) void'(vec_q.pop_front());
      end
    end
  end

  initial begin : ready_drv
    a_tready = 1'b0;
    b_tready = 1'b0;
    m_res_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      a_tready     = pick(a_mode);
      b_tready     = pick(b_mode);
      m_res_tready = pick(r_mode);
    end
  end

  // MAC stand-in: one row total per A tlast seen, plus optional partial sums.
  initial begin : mac_drv
    logic [32:0] e;
    r_tvalid = 1'b0;
    r_tlast  = 1'b0;
    r_tdata  = '0;
    forever begin
      @(posedge clk); #1;
      r_tvalid = 1'b0;
      r_tlast  = 1'b0;
      if (!aresetn) begin
        res_sent = a_last_cnt;
      end else if (inj_q.size() > 0) begin
        e = inj_q.pop_front();
        r_tvalid = 1'b1;
        r_tlast  = e[32];
        r_tdata  = e[31:0];
      end else if (a_last_cnt != res_sent && sum_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        r_tvalid = 1'b1;
        r_tlast  = 1'b1;
        r_tdata  = sum_q.pop_front();
        res_sent++;
      end else if (partials != 0 && $urandom_range(0, 3) == 0) begin
        r_tvalid = 1'b1;
        r_tdata  = $urandom;
      end
    end
  end

  initial begin : monitor
    logic [32:0] ea;
    forever begin
      @(negedge clk);
      if (aresetn) begin
        if (a_tvalid && a_tready) begin
          a_fires++;
          if (a_tlast) a_last_cnt++;
          ea = (exp_a.size() > 0) ? exp_a.pop_front() : 33'h1_dead_beef;
          check("a_beat", 64'({a_tlast, a_tdata}), 64'(ea));
        end
        if (b_tvalid && b_tready) begin
          b_fires++;
          check("b_beat", 64'(b_tdata), (exp_b.size() > 0) ? 64'(exp_b.pop_front()) : 64'hdead_beef_0);
        end
        if (m_res_tvalid && m_res_tready) begin
          check("m_res", m_res_tdata, (exp_res.size() > 0) ? exp_res.pop_front() : 64'hffff_0000_dead_beef);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a0, b0, n, stuck;
    aresetn = 1'b0;
    cycles(3);
    check("rst_a_tvalid", 64'(a_tvalid), 64'd0);
    check("rst_b_tvalid", 64'(b_tvalid), 64'd0);
    check("rst_a_tlast", 64'(a_tlast), 64'd0);
    check("rst_m_res_tvalid", 64'(m_res_tvalid), 64'd0);
    check("rst_cmd_tready", 64'(s_cmd_tready), 64'd0);
    check("rst_in_tready", 64'({s_val_tready, s_vec_tready}), 64'd0);
    check("rst_err", 64'(err_orphan), 64'd0);
    aresetn = 1'b1;
    cycles(1);
    check("idle_cmd_tready", 64'(s_cmd_tready), 64'd1);

    // 1.0*1.0 + 2.0*1.0 + 3.0*1.0 = 6.0
    r_mode = 2;
    stg_val.push_back(32'h3F80_0000); stg_val.push_back(32'h4000_0000); stg_val.push_back(32'h4040_0000);
    repeat (3) stg_vec.push_back(32'h3F80_0000);
    add_row(32'd5, 16'd3, 32'h40C0_0000);
    wait_idle(300);

    add_row(32'd9, 16'd0, 32'h0);
    wait_idle(300);

    // A stalled, B free: B completes once, inputs held off until A completes.
    a_mode = 1; b_mode = 2;
    a0 = a_fires; b0 = b_fires;
    add_row(32'd7, 16'd2, $urandom);
    n = 0;
    while (!a_tvalid && n < 50) begin @(negedge clk); n++; end
    check("stall_a_valid_seen", 64'(a_tvalid), 64'd1);
    stuck = 0;
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      if (s_val_tready || s_vec_tready) stuck++;
    end
    check("stall_in_tready", 64'(stuck), 64'd0);
    check("stall_b_once", 64'(b_fires - b0), 64'd1);
    check("stall_a_none", 64'(a_fires - a0), 64'd0);
    a_mode = 2;
    wait_idle(300);
    check("stall_a_pairs", 64'(a_fires - a0), 64'd2);
    check("stall_b_pairs", 64'(b_fires - b0), 64'd2);

    // Credit limit: four rows outstanding blocks the fifth command.
    r_mode = 1;
    a0 = cmd_acc;
    for (int i = 0; i < 5; i++) add_row(32'(i), 16'd1, $urandom);
    n = 0;
    while (cmd_acc - a0 < 4 && n < 200) begin @(negedge clk); n++; end
    cycles(20);
    check("credit_accepts", 64'(cmd_acc - a0), 64'd4);
    check("credit_cmd_tready_low", 64'(s_cmd_tready), 64'd0);
    check("credit_res_valid", 64'(m_res_tvalid), 64'd1);
    r_mode = 2;
    @(negedge clk);
    check("credit_pop_cycle_tready", 64'({m_res_tready, s_cmd_tready}), 64'b10);
    @(negedge clk);
    check("credit_tready_after_pop", 64'(s_cmd_tready), 64'd1);
    wait_idle(500);

    // Partial sums are ignored; a total with no row pending is an orphan.
    partials = 0;
    cycles(5);
    inj_q.push_back({1'b0, 32'h1234_5678});
    cycles(4);
    check("partial_no_res", 64'({m_res_tvalid, err_orphan}), 64'd0);
    inj_q.push_back({1'b1, 32'hABCD_0001});
    cycles(4);
    check("orphan_flag", 64'(err_orphan), 64'd1);
    check("orphan_no_res", 64'(m_res_tvalid), 64'd0);
    cycles(10);
    check("orphan_sticky", 64'(err_orphan), 64'd1);

    // Reset in the middle of a row.
    a0 = a_fires;
    add_row(32'h77, 16'd4, $urandom);
    n = 0;
    while (a_fires - a0 < 2 && n < 100) begin @(negedge clk); n++; end
    aresetn = 1'b0;
    cycles(1);
    check("mid_rst_valids", 64'({a_tvalid, b_tvalid, m_res_tvalid}), 64'd0);
    check("mid_rst_err", 64'(err_orphan), 64'd0);
    cmd_q.delete(); val_q.delete(); vec_q.delete();
    exp_a.delete(); exp_b.delete(); exp_res.delete(); sum_q.delete(); inj_q.delete();
    cycles(2);
    aresetn = 1'b1;
    cycles(1);
    check("post_rst_cmd_tready", 64'(s_cmd_tready), 64'd1);
    add_row(32'h55, 16'd1, 32'h3F80_0000);
    wait_idle(300);

    // Randomized traffic.
    bubbles = 1; partials = 1;
    a_mode = 0; b_mode = 0; r_mode = 0;
    for (int i = 0; i < 40; i++) add_row($urandom, 16'($urandom_range(0, 6)), $urandom);
    wait_idle(5000);
    check("final_err_clear", 64'(err_orphan), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
